// File: rtl/agent_config_loader_pkg.sv
// agent_config_loader shared definitions: opcodes, header layout, agent states, error bits.
// Optional readback opcode enabled by AGENT_STATE_READBACK_EN.
package disease_pkg;

    localparam logic [3:0] OP_SEED  = 4'h1;
    localparam logic [3:0] OP_STATE = 4'h2;
    localparam logic [3:0] OP_CONN  = 4'h3;
    localparam logic [3:0] OP_READ  = 4'h4;

    localparam int HDR_OP_LSB  = 28;
    localparam int HDR_ST_BIT  = 16;
    localparam int HDR_IDX_LSB = 0;
    localparam int HDR_IDX_W   = 16;

    localparam logic SUS = 1'b0;
    localparam logic INF = 1'b1;

    localparam int ERR_OPCODE = 0;
    localparam int ERR_RANGE  = 1;
    localparam int ERR_CONN   = 2;

    typedef struct packed {
        logic [3:0]  op;
        logic [10:0] rsvd;
        logic        st;
        logic [15:0] idx;
    } hdr_t;

endpackage

// File: rtl/agent_config_loader_if.sv
// Command stream (s_*) and readback stream (m_*) handshakes of agent_config_loader.
// The m_* side only carries data when AGENT_STATE_READBACK_EN is defined.
interface agent_config_loader_if;

    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

endinterface

// File: rtl/agent_config_loader_counter.sv
// cfg_word_counter: payload/readback word counter with load, increment and terminal flag.
// Shared by CONN_D, DRAIN and RB in agent_config_loader.
module cfg_word_counter #(
    parameter int WIDTH = 2,
    parameter int LAST  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             inc,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // load wins over increment; count holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= ld_val;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == WIDTH'(LAST));

endmodule

// File: rtl/agent_config_loader.sv
// agent_config_loader: decodes the host command stream into agent load pulses.
// Define AGENT_STATE_READBACK_EN to add opcode READ and the agentStates readback.
module agent_config_loader
    import disease_pkg::*;
#(
    parameter int numAgents = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    agent_config_loader_if.slave bus,
`ifdef AGENT_STATE_READBACK_EN
    input  logic [numAgents-1:0] agentStates,
`endif
    output logic [31:0]          address,
    output logic [31:0]          seedValue,
    output logic                 loadSeed,
    output logic                 initState,
    output logic                 loadState,
    output logic [numAgents-1:0] loadConnectivity,
    output logic [31:0]          valConnectivity,
    output logic [2:0]           err
);

    localparam int WPA = (numAgents + 31) / 32;
    localparam int CW  = (WPA > 1) ? $clog2(WPA) : 1;
    localparam int IW  = (numAgents > 1) ? $clog2(numAgents) : 1;

    localparam logic [15:0] NA16 = 16'(numAgents);
    localparam logic [numAgents-1:0] ONE = numAgents'(1);

    localparam logic [2:0] HDR    = 3'd0;
    localparam logic [2:0] SEED_D = 3'd1;
    localparam logic [2:0] CONN_D = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
`ifdef AGENT_STATE_READBACK_EN
    localparam logic [2:0] RB     = 3'd4;
    localparam int SNAPW = WPA * 32;
`endif

    logic [2:0]           state;
    logic                 rdy_q;
    logic [15:0]          idx_q;
    logic                 drop_q;
    logic [numAgents-1:0] conn_loaded;

    hdr_t    hdr;
    logic    acc;
    logic    in_range;
    logic    conn_hit;
    logic    cnt_clr;
    logic    cnt_inc;
    logic    cnt_tc;
    logic    rb_fire;
    logic [IW-1:0] hidx;

    assign hdr      = bus.s_data;
    assign acc      = bus.s_valid & rdy_q;
    assign in_range = hdr.idx < NA16;
    assign hidx     = hdr.idx[IW-1:0];
    assign conn_hit = in_range && conn_loaded[hidx];
    assign cnt_clr  = (state == HDR) & acc;
    assign cnt_inc  = (acc & ((state == CONN_D) | (state == DRAIN))) | rb_fire;

    assign bus.s_ready = rdy_q;

`ifdef AGENT_STATE_READBACK_EN
    logic             mv_q;
    logic [31:0]      md_q;
    logic [SNAPW-1:0] snap;
    logic [SNAPW-1:0] snap_in;

    assign snap_in     = SNAPW'(agentStates);
    assign rb_fire     = (state == RB) & mv_q & bus.m_ready;
    assign bus.m_valid = mv_q;
    assign bus.m_data  = md_q;

    logic unused_ok;
    assign unused_ok = ^hdr.rsvd;
`else
    assign rb_fire     = 1'b0;
    assign bus.m_valid = 1'b0;
    assign bus.m_data  = 32'h0;

    logic unused_ok;
    assign unused_ok = ^{hdr.rsvd, bus.m_ready};
`endif

    cfg_word_counter #(
        .WIDTH (CW),
        .LAST  (WPA - 1)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_clr),
        .ld_val ({CW{1'b0}}),
        .inc    (cnt_inc),
        .tc     (cnt_tc)
    );

    // command FSM: header decode, payload routing and registered load pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= HDR;
            rdy_q            <= 1'b0;
            idx_q            <= '0;
            drop_q           <= 1'b0;
            conn_loaded      <= '0;
            address          <= '0;
            seedValue        <= '0;
            loadSeed         <= 1'b0;
            initState        <= SUS;
            loadState        <= 1'b0;
            loadConnectivity <= '0;
            valConnectivity  <= '0;
            err              <= '0;
`ifdef AGENT_STATE_READBACK_EN
            mv_q             <= 1'b0;
            md_q             <= '0;
            snap             <= '0;
`endif
        end else begin
            rdy_q            <= 1'b1;
            loadSeed         <= 1'b0;
            loadState        <= 1'b0;
            loadConnectivity <= '0;
            unique case (state)
                HDR: begin
                    if (acc) begin
                        case (hdr.op)
                            OP_STATE: begin
                                if (in_range) begin
                                    loadState <= 1'b1;
                                    address   <= 32'(hdr.idx);
                                    initState <= hdr.st;
                                end else begin
                                    err[ERR_RANGE] <= 1'b1;
                                end
                            end
                            OP_SEED: begin
                                idx_q  <= hdr.idx;
                                drop_q <= !in_range;
                                if (!in_range) begin
                                    err[ERR_RANGE] <= 1'b1;
                                end
                                state <= SEED_D;
                            end
                            OP_CONN: begin
                                idx_q <= hdr.idx;
                                if (!in_range) begin
                                    err[ERR_RANGE] <= 1'b1;
                                    state <= DRAIN;
                                end else if (conn_hit) begin
                                    err[ERR_CONN] <= 1'b1;
                                    state <= DRAIN;
                                end else begin
                                    state <= CONN_D;
                                end
                            end
`ifdef AGENT_STATE_READBACK_EN
                            OP_READ: begin
                                mv_q  <= 1'b1;
                                md_q  <= snap_in[31:0];
                                snap  <= snap_in >> 32;
                                rdy_q <= 1'b0;
                                state <= RB;
                            end
`endif
                            default: begin
                                err[ERR_OPCODE] <= 1'b1;
                            end
                        endcase
                    end
                end
                SEED_D: begin
                    if (acc) begin
                        if (!drop_q) begin
                            loadSeed  <= 1'b1;
                            seedValue <= bus.s_data;
                            address   <= 32'(idx_q);
                        end
                        state <= HDR;
                    end
                end
                CONN_D: begin
                    if (acc) begin
                        loadConnectivity <= ONE << idx_q;
                        valConnectivity  <= bus.s_data;
                        address          <= 32'(idx_q);
                        if (cnt_tc) begin
                            conn_loaded[idx_q[IW-1:0]] <= 1'b1;
                            state <= HDR;
                        end
                    end
                end
                DRAIN: begin
                    if (acc && cnt_tc) begin
                        state <= HDR;
                    end
                end
`ifdef AGENT_STATE_READBACK_EN
                RB: begin
                    if (rb_fire && cnt_tc) begin
                        mv_q  <= 1'b0;
                        state <= HDR;
                    end else begin
                        rdy_q <= 1'b0;
                        if (rb_fire) begin
                            md_q <= snap[31:0];
                            snap <= snap >> 32;
                        end
                    end
                end
`endif
                default: begin
                    state <= HDR;
                end
            endcase
        end
    end

endmodule
